// File: rtl/qif_pkg.sv
// Shared definitions for the QIF spike decoder: FSM state type and window timing.
package qif_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   localparam int unsigned WIN_BASE_LEN = 256;
   // Longest window is 256 << 7 = 32768 cycles, so its last index needs 15 bits.
   localparam int WIN_CNT_W = 15;

   function automatic logic [WIN_CNT_W-1:0] win_last(input logic [2:0] sel);
      return WIN_CNT_W'((WIN_BASE_LEN << sel) - 1);
   endfunction

endpackage

// File: rtl/qif_spike_counter.sv
// Rising-edge detector on the spike input plus a per-window saturating spike counter.
module qif_spike_counter #(
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spike,
   input  logic              count_en,
   input  logic              win_end,
   output logic              spike_edge,
   output logic [RATE_W-1:0] count_total
);

   localparam logic [RATE_W-1:0] CNT_MAX = '1;

   logic              spike_q;
   logic [RATE_W-1:0] count_q;

   assign spike_edge = spike & ~spike_q;

   // count_total already includes an edge on the current cycle, so a spike on
   // the window-end cycle lands in the closing window.
   always_comb begin
      // NOTE: default first so every path assigns count_total and no latch is inferred.
      count_total = count_q;
      if (count_en && spike_edge && (count_q != CNT_MAX)) begin
         count_total = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_q <= 1'b0;
         count_q <= '0;
      end else begin
         spike_q <= spike;
         if (!count_en || win_end) begin
            count_q <= '0;
         end else begin
            count_q <= count_total;
         end
      end
   end

endmodule

// File: rtl/qif_spike_decoder.sv
// Windowed spike-rate decoder with a valid/ready result register and sticky overrun flag.
// Define QIF_DEC_ISI_EN to build in inter-spike-interval measurement; otherwise isi_o is 0.
module qif_spike_decoder
   import qif_pkg::*;
#(
   parameter int RATE_W = 8,
   parameter int ISI_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              spike_i,
   input  logic [2:0]        win_sel_i,
   output logic [RATE_W-1:0] rate_o,
   output logic [ISI_W-1:0]  isi_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              overrun_o
);

   state_e               state_q;
   logic [WIN_CNT_W-1:0] win_cnt_q;
   logic [WIN_CNT_W-1:0] win_last_q;
   logic                 active;
   logic                 start;
   logic                 win_end;
   logic                 handshake;
   logic                 spike_edge;
   logic [RATE_W-1:0]    count_total;

   // The cycle en_i drops is already treated as idle, so a partial window never closes.
   assign active    = (state_q == COUNT) && en_i;
   assign start     = (state_q == IDLE) && en_i;
   assign win_end   = active && (win_cnt_q == win_last_q);
   assign handshake = valid_o && ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         win_cnt_q  <= '0;
         win_last_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= en_i ? COUNT : IDLE;
         if (!active || win_end) begin
            win_cnt_q <= '0;
         end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
         end
         if (start || win_end) begin
            win_last_q <= win_last(win_sel_i);
         end
      end
   end

   qif_spike_counter #(
      .RATE_W (RATE_W)
   ) u_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .spike       (spike_i),
      .count_en    (active),
      .win_end     (win_end),
      .spike_edge  (spike_edge),
      .count_total (count_total)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rate_o    <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else if (win_end) begin
         rate_o    <= count_total;
         valid_o   <= 1'b1;
         // Unaccepted result gets overwritten; a same-cycle handshake clears the flag.
         overrun_o <= valid_o && !ready_i;
      end else if (handshake) begin
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end
   end

`ifdef QIF_DEC_ISI_EN
   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   logic [ISI_W-1:0] isi_timer_q;
   logic [ISI_W-1:0] isi_lat_q;
   logic [ISI_W-1:0] isi_next;
   logic             seen_edge_q;

   assign isi_next = (spike_edge && seen_edge_q) ? isi_timer_q : isi_lat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi_timer_q <= '0;
         isi_lat_q   <= '0;
         seen_edge_q <= 1'b0;
      end else if (!active) begin
         isi_timer_q <= '0;
         isi_lat_q   <= '0;
         seen_edge_q <= 1'b0;
      end else if (spike_edge) begin
         isi_timer_q <= ISI_W'(1);
         isi_lat_q   <= isi_next;
         seen_edge_q <= 1'b1;
      end else if (isi_timer_q != ISI_MAX) begin
         isi_timer_q <= isi_timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi_o <= '0;
      end else if (win_end) begin
         isi_o <= isi_next;
      end
   end
`else
   logic unused_spike_edge;
   assign unused_spike_edge = spike_edge;
   assign isi_o = '0;
`endif

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Self-checking bench for qif_spike_decoder: directed scenarios plus random traffic vs. a window model.
module tb_qif_spike_decoder;

   localparam int RATE_W   = 8;
   localparam int ISI_W    = 16;
   localparam int RATE_MAX = (1 << RATE_W) - 1;
   localparam int ISI_MAX  = (1 << ISI_W) - 1;
`ifdef QIF_DEC_ISI_EN
   localparam bit ISI_ON = 1'b1;
`else
   localparam bit ISI_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en_i = 1'b0;
   logic              spike_i = 1'b0;
   logic [2:0]        win_sel_i = 3'd0;
   logic              ready_i = 1'b0;
   logic [RATE_W-1:0] rate_o;
   logic [ISI_W-1:0]  isi_o;
   logic              valid_o;
   logic              overrun_o;

   qif_spike_decoder #(
      .RATE_W (RATE_W),
      .ISI_W  (ISI_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .spike_i   (spike_i),
      .win_sel_i (win_sel_i),
      .rate_o    (rate_o),
      .isi_o     (isi_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .overrun_o (overrun_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a window is just a cycle position, a length and a tally of edges.
   int m_now = 0, m_pos = 0, m_len = 256, m_cnt = 0, m_last = 0, m_isi = 0;
   bit m_in_count = 0, m_prev = 0, m_have_edge = 0;
   int e_rate = 0, e_isi = 0;
   bit e_valid = 0, e_ovr = 0;

   task automatic model_reset();
      m_now = 0; m_pos = 0; m_len = 256; m_cnt = 0; m_last = 0; m_isi = 0;
      m_in_count = 0; m_prev = 0; m_have_edge = 0;
      e_rate = 0; e_isi = 0; e_valid = 0; e_ovr = 0;
   endtask

   task automatic model_step();
      bit edge_now, hs;
      m_now++;
      edge_now = spike_i && !m_prev;
      m_prev = spike_i;
      hs = e_valid && ready_i;
      if (m_in_count && en_i) begin
         if (edge_now) begin
            m_cnt++;
            if (m_have_edge) m_isi = (m_now - m_last > ISI_MAX) ? ISI_MAX : m_now - m_last;
            m_last = m_now;
            m_have_edge = 1;
         end
         if (m_pos == m_len - 1) begin
            if (e_valid && !ready_i) e_ovr = 1;
            else if (hs) e_ovr = 0;
            e_valid = 1;
            e_rate = (m_cnt > RATE_MAX) ? RATE_MAX : m_cnt;
            e_isi = ISI_ON ? m_isi : 0;
            m_pos = 0;
            m_cnt = 0;
            m_len = 256 << win_sel_i;
         end else begin
            m_pos++;
            if (hs) begin e_valid = 0; e_ovr = 0; end
         end
      end else begin
         if (hs) begin e_valid = 0; e_ovr = 0; end
         m_in_count = en_i;
         m_pos = 0; m_cnt = 0; m_len = 256 << win_sel_i;
         m_have_edge = 0; m_isi = 0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("model_valid",   32'(valid_o),   32'(e_valid));
         check("model_overrun", 32'(overrun_o), 32'(e_ovr));
         check("model_rate",    32'(rate_o),    e_rate);
         check("model_isi",     32'(isi_o),     e_isi);
      end
   end

   task automatic cyc(input logic sp);
      spike_i = sp;
      @(negedge clk);
      #1;
   endtask

   int first_k;

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("reset_rate",    32'(rate_o),    0);
      check("reset_valid",   32'(valid_o),   0);
      check("reset_overrun", 32'(overrun_o), 0);
      check("reset_isi",     32'(isi_o),     0);
      rst_n = 1'b1;

      // Rate count, boundary spike and back-to-back windows.
      en_i = 1; win_sel_i = 0; ready_i = 1; first_k = 0;
      for (int k = 1; k <= 770; k++) begin
         cyc(((k % 20 == 0) && k <= 200) || k == 513 || k == 515);
         if (valid_o && first_k == 0) first_k = k;
         if (k == 257) begin
            check("win1_valid", 32'(valid_o), 1);
            check("win1_rate",  32'(rate_o), 10);
         end
         if (k == 513) check("boundary_rate", 32'(rate_o), 1);
         if (k == 769) check("next_win_rate", 32'(rate_o), 1);
      end
      check("first_valid_cycle", first_k, 257);

      // Saturation with a toggling spike over a 512-cycle window.
      en_i = 0; ready_i = 1;
      repeat (3) cyc(0);
      en_i = 1; win_sel_i = 1; first_k = 0;
      for (int k = 1; k <= 515; k++) begin
         cyc(k % 2 == 1);
         if (valid_o && first_k == 0) begin
            first_k = k;
            check("sat_rate", 32'(rate_o), 255);
         end
      end
      check("sat_valid_cycle", first_k, 513);

      // Overrun across two window ends, then a single-cycle accept.
      en_i = 0; ready_i = 1;
      repeat (3) cyc(0);
      en_i = 1; win_sel_i = 0; ready_i = 0;
      for (int k = 1; k <= 513; k++) begin
         cyc(k inside {10, 20, 30, 300, 310, 320, 330, 340});
      end
      check("ovr_valid",   32'(valid_o),   1);
      check("ovr_flag",    32'(overrun_o), 1);
      check("ovr_rate",    32'(rate_o),    5);
      ready_i = 1;
      cyc(0);
      ready_i = 0;
      check("accept_valid", 32'(valid_o),   0);
      check("accept_ovr",   32'(overrun_o), 0);

      // Inter-spike interval at 40-cycle spacing.
      en_i = 0; ready_i = 1;
      repeat (3) cyc(0);
      en_i = 1; ready_i = 0;
      for (int k = 1; k <= 257; k++) begin
         cyc(k inside {10, 50, 90, 130, 170});
      end
      check("isi_valid", 32'(valid_o), 1);
      check("isi_rate",  32'(rate_o), 5);
      check("isi_value", 32'(isi_o), ISI_ON ? 40 : 0);

      // Asynchronous reset mid-window with a pending result.
      repeat (30) cyc(0);
      check("pre_reset_valid", 32'(valid_o), 1);
      rst_n = 1'b0;
      #1;
      check("async_rate",    32'(rate_o),    0);
      check("async_isi",     32'(isi_o),     0);
      check("async_valid",   32'(valid_o),   0);
      check("async_overrun", 32'(overrun_o), 0);
      repeat (2) cyc(0);
      rst_n = 1'b1;

      // Random traffic against the model.
      en_i = 1;
      for (int k = 0; k < 6000; k++) begin
         if ($urandom_range(0, 149) == 0) en_i = ~en_i;
         win_sel_i = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0;
         ready_i = ($urandom_range(0, 5) == 0);
         if (k == 3000) begin
            rst_n = 1'b0;
            cyc(0);
            rst_n = 1'b1;
         end
         cyc($urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/qif_spike_decoder.md
QIF_SPIKE_DECODER -- requirements
Module: qif_spike_decoder

Interface
REQ-001 SHALL have parameter RATE_W, default 8: spike-count result width.
REQ-002 SHALL have parameter ISI_W, default 16: inter-spike-interval result width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en_i, input, 1: decoder enable.
REQ-006 SHALL have port spike_i, input, 1: neuron spike output, synchronous to clk.
REQ-007 SHALL have port win_sel_i, input, 3: window length select, L = 256 << win_sel_i cycles.
REQ-008 SHALL have port rate_o, output, RATE_W: spikes counted in the last completed window.
REQ-009 SHALL have port isi_o, output, ISI_W: last measured inter-spike interval in cycles.
REQ-010 SHALL have port valid_o, output, 1: result available.
REQ-011 SHALL have port ready_i, input, 1: consumer accepts the result.
REQ-012 SHALL have port overrun_o, output, 1: sticky flag; a result was overwritten before acceptance.

Function
REQ-013 SHALL count one spike per rising edge of spike_i, using a 1-cycle registered previous value; a held-high spike_i counts once.
REQ-014 SHALL use FSM states IDLE, COUNT: IDLE->COUNT when en_i=1; COUNT->IDLE when en_i=0.
REQ-015 SHALL clear the window counter, spike counter and ISI timer, and hold them cleared, in IDLE.
REQ-016 SHALL sample win_sel_i only on the IDLE->COUNT transition and at each window boundary; mid-window changes take effect at the next window.
REQ-017 SHALL, in COUNT, declare a window end on the cycle the window counter reaches L-1, then restart the window counter at 0 on the next cycle with no gap.
REQ-018 SHALL count a spike edge that coincides with the window-end cycle in the closing window.
REQ-019 SHALL saturate the spike count at 2^RATE_W-1.
REQ-020 SHALL, at window end, load the count into rate_o and assert valid_o on the next cycle (latency 1).
REQ-021 SHALL clear valid_o on a cycle with valid_o=1 and ready_i=1, unless a new window end occurs on the same cycle, in which case valid_o stays 1 with the new result.
REQ-022 SHALL, on a window end while valid_o=1 and ready_i=0, overwrite rate_o/isi_o and set overrun_o.
REQ-023 SHALL hold overrun_o at 1 until a handshake (valid_o & ready_i) completes.
REQ-024 SHALL keep rate_o/isi_o stable while valid_o=1 and no window end occurs.
REQ-025 SHALL, when en_i falls mid-window, discard the partial window; an already-valid result remains valid until accepted.

Reset
REQ-026 SHALL, on rst_n=0, immediately force IDLE, all counters to 0, rate_o=0, isi_o=0, valid_o=0 and overrun_o=0.
REQ-027 SHALL, when reset is asserted mid-window, drop any pending result without a handshake.

Configuration
REQ-028 SHALL compile ISI measurement in when the macro QIF_DEC_ISI_EN is defined. When defined:
- a timer counts cycles since the last spike edge, saturating at 2^ISI_W-1;
- on each edge after the first, the timer value is latched as the ISI and the timer restarts at 1;
- the latched ISI is copied to isi_o at window end.
REQ-029 SHALL, without QIF_DEC_ISI_EN, tie isi_o to 0 and instantiate no ISI timer logic.

Structure
REQ-030 SHALL take the FSM state enum and the window base length constant (256) from the shared package qif_pkg.
REQ-031 SHALL implement edge detection plus the saturating spike counter as the sub-module qif_spike_counter.

Verification
REQ-032 Rate count: en_i=1, win_sel_i=0, 10 single-cycle spikes in window -> valid_o=1 at cycle 257, rate_o=10.
REQ-033 Boundary spike: spike edge on cycle 255 of the window -> counted in that window; the next window starts at 0.
REQ-034 Saturation: spike_i toggling every cycle, win_sel_i=1 (L=512) -> rate_o=255.
REQ-035 Overrun: ready_i=0 across two window ends -> overrun_o=1 and rate_o shows the second count; ready_i=1 for one cycle -> valid_o=0 and overrun_o=0.
REQ-036 ISI with QIF_DEC_ISI_EN: spikes at 40-cycle spacing -> isi_o=40; without the macro -> isi_o=0.
REQ-037 Async reset: rst_n=0 mid-window with valid_o=1 -> all outputs 0 immediately, without a clock edge.
